// File: rtl/bus_enable_arbiter4.sv
// Four-source round-robin arbiter producing registered one-hot tri-state enables.
// Optional macro BUS_TURNAROUND_EN inserts a one-cycle dead GAP between owners.

module bus_enable_arbiter4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] en,
    output logic [1:0] owner,
    output logic       busy
);

`ifdef BUS_TURNAROUND_EN
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] en_q, en_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;
    logic [7:0] cnt_q, cnt_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic [3:0] win_onehot;
    logic       owner_drop;
    logic       hold_expired;
    logic       release_now;
    logic       arbitrate;

    // Search starts just past the most recent grantee, so it always ranks last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_onehot   = 4'b0001 << win_idx;
    assign owner_drop   = !req[owner_q];
    assign hold_expired = (cnt_q == HOLD_LAST) && ((req & ~en_q) != 4'b0000);
    assign release_now  = owner_drop || hold_expired;

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        arbitrate = 1'b0;

        case (state_q)
            IDLE: arbitrate = 1'b1;
`ifdef BUS_TURNAROUND_EN
            GAP:  arbitrate = 1'b1;
`endif
            GRANT: begin
                if (release_now) begin
                    cnt_d = 8'd0;
`ifdef BUS_TURNAROUND_EN
                    state_d = GAP;
                    en_d    = 4'b0000;
`else
                    // Direct hand-over: the winner can never be the releasing owner.
                    if (win_found) begin
                        state_d = GRANT;
                        en_d    = win_onehot;
                        owner_d = win_idx;
                        last_d  = win_idx;
                    end else begin
                        state_d = IDLE;
                        en_d    = 4'b0000;
                    end
`endif
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                en_d    = 4'b0000;
                cnt_d   = 8'd0;
            end
        endcase

        if (arbitrate) begin
            if (win_found) begin
                state_d = GRANT;
                en_d    = win_onehot;
                owner_d = win_idx;
                last_d  = win_idx;
                cnt_d   = 8'd0;
            end else begin
                state_d = IDLE;
                en_d    = 4'b0000;
            end
        end
    end

    // last resets to 3 so source 0 is searched first after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            en_q    <= 4'b0000;
            owner_q <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign en    = en_q;
    assign owner = owner_q;
    assign busy  = |en_q;

endmodule

// File: tb/tb_bus_enable_arbiter4.sv
// Directed and random checks for bus_enable_arbiter4 (MAX_HOLD = 8).

module tb_bus_enable_arbiter4;

    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] en;
    logic [1:0] owner;
    logic       busy;

    int checks = 0;
    int errors = 0;

    bus_enable_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .en    (en),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        #2;
        checks++;
        if (en !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: en=%b busy=%b owner=%0d expected 0000/0/0", en, busy, owner);
        end
        tick();
        checks++;
        if (en !== 4'b0000) begin
            errors++;
            $display("FAIL reset_edge: en=%b expected 0000", en);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (en !== 4'b0000) begin
            errors++;
            $display("FAIL reset_exit_early: en=%b expected 0000", en);
        end
        tick();
        checks++;
        if (en !== 4'b0001 || owner !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: en=%b owner=%0d busy=%b expected 0001/0/1", en, owner, busy);
        end
    endtask

    task automatic test_single();
        apply_reset();
        req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (en !== 4'b0001 || busy !== 1'b1) begin
                errors++;
                $display("FAIL single_hold cycle %0d: en=%b busy=%b expected 0001/1", k, en, busy);
            end
        end
        req = 4'b0000;
        tick();
        checks++;
        if (en !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_release: en=%b busy=%b expected 0000/0", en, busy);
        end
    endtask

    task automatic test_rotate();
        logic [3:0] exp_en;
        apply_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_en = 4'(1 << (g % 4));
            for (int k = 0; k < MAX_HOLD; k++) begin
                tick();
                checks++;
                if (en !== exp_en || owner !== 2'(g % 4)) begin
                    errors++;
                    $display("FAIL rotate grant %0d cycle %0d: en=%b owner=%0d expected %b/%0d",
                             g, k, en, owner, exp_en, g % 4);
                end
            end
`ifdef BUS_TURNAROUND_EN
            if (g < 4) begin
                tick();
                checks++;
                if (en !== 4'b0000 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL rotate_gap %0d: en=%b busy=%b expected 0000/0", g, en, busy);
                end
            end
`endif
        end
    endtask

    task automatic test_hold();
        apply_reset();
        req = 4'b0100;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (en !== 4'b0100 || owner !== 2'd2) begin
                errors++;
                $display("FAIL hold cycle %0d: en=%b owner=%0d expected 0100/2", k, en, owner);
            end
        end
        // Counter is saturated, so a competing request forces hand-over at once.
        req = 4'b0101;
        tick();
`ifdef BUS_TURNAROUND_EN
        checks++;
        if (en !== 4'b0000) begin
            errors++;
            $display("FAIL hold_gap: en=%b expected 0000", en);
        end
        tick();
`endif
        checks++;
        if (en !== 4'b0001 || owner !== 2'd0) begin
            errors++;
            $display("FAIL hold_forced_release: en=%b owner=%0d expected 0001/0", en, owner);
        end
    endtask

    task automatic test_drop_timeout();
        apply_reset();
        req = 4'b0010;
        tick();
        checks++;
        if (en !== 4'b0010) begin
            errors++;
            $display("FAIL drop_to_first: en=%b expected 0010", en);
        end
        for (int k = 1; k < MAX_HOLD; k++) begin
            req = {1'b1, k[0], 1'b1, k[1]};
            tick();
            checks++;
            if (en !== 4'b0010) begin
                errors++;
                $display("FAIL drop_to_nonowner cycle %0d: en=%b expected 0010", k, en);
            end
        end
        req = 4'b1000;
        tick();
`ifdef BUS_TURNAROUND_EN
        checks++;
        if (en !== 4'b0000) begin
            errors++;
            $display("FAIL drop_to_gap: en=%b expected 0000", en);
        end
        tick();
`endif
        checks++;
        if (en !== 4'b1000 || owner !== 2'd3) begin
            errors++;
            $display("FAIL drop_to_next: en=%b owner=%0d expected 1000/3", en, owner);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] pat [4];
        logic [3:0] exp [4];
        pat = '{4'b0110, 4'b0101, 4'b0001, 4'b0000};
        exp = '{4'b0010, 4'b0100, 4'b0001, 4'b0000};
        apply_reset();
        req = 4'b0001;
        tick();
        for (int s = 0; s < 4; s++) begin
            req = pat[s];
            tick();
`ifdef BUS_TURNAROUND_EN
            if (s < 3) begin
                checks++;
                if (en !== 4'b0000) begin
                    errors++;
                    $display("FAIL b2b_gap step %0d: en=%b expected 0000", s, en);
                end
                tick();
            end
`endif
            checks++;
            if (en !== exp[s]) begin
                errors++;
                $display("FAIL b2b step %0d: en=%b expected %b", s, en, exp[s]);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 4'b0010;
        tick();
        checks++;
        if (en !== 4'b0010) begin
            errors++;
            $display("FAIL async_pre: en=%b expected 0010", en);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (en !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL async_clear: en=%b busy=%b owner=%0d expected 0000/0/0", en, busy, owner);
        end
        tick();
        rst = 1'b0;
        req = 4'b1010;
        tick();
        checks++;
        if (en !== 4'b0010 || owner !== 2'd1) begin
            errors++;
            $display("FAIL async_regrant: en=%b owner=%0d expected 0010/1", en, owner);
        end
    endtask

    task automatic test_random();
        logic [3:0] prev_en;
        int wait_c [4];
        apply_reset();
        prev_en = 4'b0000;
        for (int b = 0; b < 4; b++) wait_c[b] = 0;
        for (int n = 0; n < 10000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 15) == 0) req[b] = ~req[b];
            tick();
            checks++;
            if ((en & (en - 4'd1)) != 4'b0000 || busy !== (|en)) begin
                errors++;
                $display("FAIL random_onehot cycle %0d: en=%b busy=%b", n, en, busy);
            end
`ifdef BUS_TURNAROUND_EN
            checks++;
            if (prev_en != 4'b0000 && en != 4'b0000 && en != prev_en) begin
                errors++;
                $display("FAIL random_adjacent cycle %0d: en=%b after %b", n, en, prev_en);
            end
`endif
            prev_en = en;
            for (int b = 0; b < 4; b++) begin
                if (req[b] && !en[b]) wait_c[b]++;
                else wait_c[b] = 0;
                checks++;
                if (wait_c[b] > 4 * MAX_HOLD + 4) begin
                    errors++;
                    $display("FAIL random_starve src %0d cycle %0d: waited %0d limit %0d",
                             b, n, wait_c[b], 4 * MAX_HOLD + 4);
                    wait_c[b] = 0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        test_reset();
        test_single();
        test_rotate();
        test_hold();
        test_drop_timeout();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
